// File: rtl/udp02467_vector_sequencer.sv
// Steps all 16 {D,A,B,C} vectors into the UDP02467 circuit and scores E/F.
// Optional first-mismatch capture ports: define UDP_FIRST_FAIL_CAPTURE_EN.
module udp02467_vector_sequencer #(
  parameter int SETTLE_CYCLES = 10,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] vec_idx,
  output logic [4:0] err_count
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
  ,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_idx,
  output logic [1:0] first_fail_ef
`endif
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       vec_q, vec_d;
  logic [4:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
  logic             ffv_q, ffv_d;
  logic [3:0]       ffi_q, ffi_d;
  logic [1:0]       ffe_q, ffe_d;
`endif

  logic [1:0] exp_ef;
  logic       mis;
  logic [4:0] err_nxt;
  logic       start_ok;
  logic       e_exp;

  // vec_q packs {d,a,b,c}; D is the inverted MSB so D=1 vectors go first
  function automatic logic [3:0] vec_of(input logic [3:0] i);
    return {~i[3], i[2:0]};
  endfunction

  // E is high for ABC minterms 0,2,4,6,7
  assign e_exp  = ~idx_q[0] | (&idx_q[2:0]);
  assign exp_ef = {e_exp, e_exp & ~idx_q[3]};

  // Case inequality so X/Z on e/f scores as a mismatch
  assign mis      = ({e, f} !== exp_ef);
  assign err_nxt  = err_q + {4'd0, mis};
  assign start_ok = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    ffe_d   = ffe_q;
`endif
    if (start_ok) begin
      state_d = RUN;
      cnt_d   = CNT_ONE;
      idx_d   = 4'd0;
      vec_d   = vec_of(4'd0);
      err_d   = 5'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
      ffv_d   = 1'b0;
      ffi_d   = 4'd0;
      ffe_d   = 2'b00;
`endif
    end else if (state_q == RUN) begin
      if (cnt_q != SETTLE_N) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        err_d = err_nxt;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
        if (mis && !ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = idx_q;
          ffe_d = {e, f};
        end
`endif
        if (idx_q != 4'd15) begin
          idx_d = idx_q + 4'd1;
          vec_d = vec_of(idx_q + 4'd1);
          cnt_d = CNT_ONE;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_nxt == 5'd0);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      vec_q   <= 4'd0;
      err_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
      ffv_q   <= 1'b0;
      ffi_q   <= 4'd0;
      ffe_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffe_q   <= ffe_d;
`endif
    end
  end

  assign {d, a, b, c} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign vec_idx      = idx_q;
  assign err_count    = err_q;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_ef    = ffe_q;
`endif

endmodule

// File: tb/tb_udp02467_vector_sequencer.sv
// Scoreboard bench: two sequencers (settle 10 and 0) around a faultable
// behavioural UDP02467 circuit, checked against a vector-loop reference.
`timescale 1ns/1ps
module tb_udp02467_vector_sequencer;

  localparam int S0 = 10;
  localparam int S1 = 0;

  logic clock   = 1'b0;
  logic reset_b = 1'b0;
  logic start0  = 1'b0;
  logic start1  = 1'b0;

  logic a0, b0, c0, d0, e0, f0, busy0, done0, pass0;
  logic a1, b1, c1, d1, e1, f1, busy1, done1, pass1;
  logic [3:0] vi0, vi1;
  logic [4:0] ec0, ec1;
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
  logic       ffv0, ffv1;
  logic [3:0] ffi0, ffi1;
  logic [1:0] ffe0, ffe1;
`endif

  int mode = 0;
  logic [15:0] mask = '0;
  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int st0    = 0;
  int st1    = 0;
  logic dp0  = 1'b0;
  logic dp1  = 1'b0;

  typedef struct {
    int         errs;
    logic       ps;
    int         lat;
    logic       ffv;
    logic [3:0] ffi;
    logic [1:0] ffe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic gold_e(input logic [2:0] m);
    return m inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
  endfunction

  // Circuit under test: 0 good, 1 F stuck-0, 2 E inverted, 3 E flipped per mask
  function automatic logic [1:0] circ(input int md, input logic [15:0] msk,
                                      input logic d, input logic a,
                                      input logic b, input logic c);
    logic e, f;
    logic [3:0] id;
    id = {~d, a, b, c};
    e = gold_e({a, b, c});
    f = e & d;
    if (md == 1) f = 1'b0;
    else if (md == 2) begin
      e = ~e;
      f = e & d;
    end else if (md == 3 && msk[id]) e = ~e;
    return {e, f};
  endfunction

  function automatic exp_t model(input int md, input logic [15:0] msk,
                                 input int settle);
    exp_t x;
    logic [3:0] iv;
    logic [1:0] want, got;
    x.errs = 0; x.ffv = 1'b0; x.ffi = '0; x.ffe = '0;
    for (int i = 0; i < 16; i++) begin
      iv   = 4'(i);
      want = {gold_e(iv[2:0]), gold_e(iv[2:0]) & ~iv[3]};
      got  = circ(md, msk, ~iv[3], iv[2], iv[1], iv[0]);
      if (got != want) begin
        if (!x.ffv) begin
          x.ffv = 1'b1; x.ffi = iv; x.ffe = got;
        end
        x.errs++;
      end
    end
    x.ps  = (x.errs == 0);
    x.lat = 16 * ((settle < 1) ? 1 : settle);
    return x;
  endfunction

  assign {e0, f0} = circ(mode, mask, d0, a0, b0, c0);
  assign {e1, f1} = circ(mode, mask, d1, a1, b1, c1);

  udp02467_vector_sequencer #(.SETTLE_CYCLES(S0), .CNT_W(8)) dut0 (
    .clock(clock), .reset_b(reset_b), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_idx(vi0), .err_count(ec0)
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv0), .first_fail_idx(ffi0), .first_fail_ef(ffe0)
`endif
  );

  udp02467_vector_sequencer #(.SETTLE_CYCLES(S1), .CNT_W(8)) dut1 (
    .clock(clock), .reset_b(reset_b), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_idx(vi1), .err_count(ec1)
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv1), .first_fail_idx(ffi1), .first_fail_ef(ffe1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int id);
    exp_t x;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      chk($sformatf("dut%0d_unexpected_done", id), 1, 0);
      return;
    end
    if (id == 0) x = q0.pop_front();
    else x = q1.pop_front();
    if (id == 0) begin
      chk("dut0_errs", ec0, x.errs);
      chk("dut0_pass", pass0, x.ps);
      chk("dut0_latency", cyc - st0, x.lat);
      chk("dut0_busy", busy0, 0);
      chk("dut0_final_vec", {d0, a0, b0, c0, vi0}, {4'b0111, 4'd15});
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
      chk("dut0_ff", {ffv0, ffi0, ffe0}, {x.ffv, x.ffi, x.ffe});
`endif
    end else begin
      chk("dut1_errs", ec1, x.errs);
      chk("dut1_pass", pass1, x.ps);
      chk("dut1_latency", cyc - st1, x.lat);
      chk("dut1_final_vec", {d1, a1, b1, c1, vi1}, {4'b0111, 4'd15});
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
      chk("dut1_ff", {ffv1, ffi1, ffe1}, {x.ffv, x.ffi, x.ffe});
`endif
    end
  endtask

  always @(negedge clock) begin
    if (done0 && !dp0) mon(0);
    if (done1 && !dp1) mon(1);
    dp0 = done0;
    dp1 = done1;
  end

  task automatic run(input int md, input logic [15:0] msk, input bit extra);
    @(negedge clock);
    mode = md;
    mask = msk;
    start0 = 1'b1;
    start1 = 1'b1;
    st0 = cyc + 1;
    st1 = cyc + 1;
    q0.push_back(model(md, msk, S0));
    q1.push_back(model(md, msk, S1));
    @(posedge clock);
    #1;
    chk("accept_state", {busy0, done0, pass0, ec0}, {3'b100, 5'd0});
    chk("accept_vec0", {d0, a0, b0, c0, vi0}, {4'b1000, 4'd0});
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    while (!(done0 && done1) && (cyc - st0) < 16 * S0 + 20) begin
      start0 = (extra && (cyc - st0) == 50);
      @(negedge clock);
    end
    start0 = 1'b0;
    chk("run_done", {done0, done1}, 2'b11);
    @(negedge clock);
  endtask

  initial begin
    #1;
    chk("rst_dut0", {a0, b0, c0, d0, busy0, done0, pass0, vi0, ec0}, 0);
    chk("rst_dut1", {a1, b1, c1, d1, busy1, done1, pass1, vi1, ec1}, 0);
    repeat (3) @(negedge clock);
    reset_b = 1'b1;
    repeat (2) @(negedge clock);

    run(0, 16'h0, 1'b0);
    run(1, 16'h0, 1'b0);
    run(2, 16'h0, 1'b0);
    run(0, 16'h0, 1'b1);
    for (int r = 0; r < 4; r++) run(3, 16'($urandom), 1'b0);

    // abort a run mid-flight
    @(negedge clock);
    mode = 0;
    start0 = 1'b1;
    start1 = 1'b1;
    st0 = cyc + 1;
    st1 = cyc + 1;
    q0.push_back(model(0, 16'h0, S0));
    q1.push_back(model(0, 16'h0, S1));
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    while ((cyc - st0) < 73) @(negedge clock);
    chk("pre_abort_busy", busy0, 1);
    reset_b = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("abort_dut0", {a0, b0, c0, d0, busy0, done0, pass0, vi0, ec0}, 0);
    chk("abort_dut1", {busy1, done1, pass1, ec1}, 0);
`ifdef UDP_FIRST_FAIL_CAPTURE_EN
    chk("abort_ff", {ffv0, ffi0, ffe0}, 0);
`endif
    repeat (2) @(negedge clock);
    reset_b = 1'b1;
    repeat (20) @(negedge clock);
    chk("idle_dut0", {a0, b0, c0, d0, busy0, done0, pass0, vi0, ec0}, 0);
    chk("idle_dut1", {a1, b1, c1, d1, busy1, done1, pass1, vi1, ec1}, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/udp02467_vector_sequencer.md
Name: udp02467_vector_sequencer

Overview:
- Self-checking stimulus/response stage wrapped around the Circuit_with_UDP02467 block (inputs A,B,C,D; outputs E,F).
- Upstream role: drives all 16 input combinations of {D,A,B,C}, each held for a programmable settle time.
- Downstream role: samples E,F for each vector and compares them against a built-in golden model.
- Reports an error count and a pass flag, so the bench replaces hand-read $display truth tables with one pass/fail result.

Parameters:
- SETTLE_CYCLES, 10, clock cycles each vector is held before E/F are sampled; a value of 0 is treated as 1.
- CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
- clock  input  1  rising-edge system clock
- reset_b  input  1  asynchronous active-low reset
- start  input  1  one-cycle run request; honoured only in IDLE or DONE
- a  output  1  stimulus A to the DUT
- b  output  1  stimulus B to the DUT
- c  output  1  stimulus C to the DUT
- d  output  1  stimulus D to the DUT
- e  input  1  DUT output E
- f  input  1  DUT output F
- busy  output  1  run in progress
- done  output  1  run complete; held until the next accepted start
- pass  output  1  done with zero mismatches
- vec_idx  output  4  index of the vector currently applied
- err_count  output  5  mismatch count, 0..16

Behaviour:
- Single clock. Reset is asynchronous, active-low on reset_b.
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, vec_idx=0, err_count=0, settle counter=0, state=IDLE.
- Vector mapping for vec_idx=i:
  - d = ~i[3], {a,b,c} = i[2:0].
  - Order is D=1 with ABC 000..111 first, then D=0 with ABC 000..111.
- Golden model:
  - E_exp = 1 for ABC minterms {0,2,4,6,7}, else 0.
  - F_exp = E_exp & D.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN when start=1 is seen at a clock edge. At that same edge:
  - busy<=1, done<=0, pass<=0, err_count<=0, vec_idx<=0.
  - a..d<=vector 0; counter<=1.
- RUN, counter < SETTLE_CYCLES: counter increments; stimulus is held.
- RUN, counter == SETTLE_CYCLES (sample edge):
  - Compare the current e,f against the golden values for vec_idx.
  - err_count increments by 1 per vector if either bit mismatches (never 2 per vector).
  - If vec_idx < 15: vec_idx++, drive the next vector, counter<=1.
  - If vec_idx == 15: state<=DONE, busy<=0, done<=1, pass<=(final err_count==0).
  - The final comparison is included in the final err_count and pass.
- Latency: done rises exactly 16*SETTLE_CYCLES clock edges after the start edge.
- In DONE, a..d and vec_idx hold vector 15 (d=0, abc=111).
- start while busy=1 is ignored; no restart and no counter effect.
- e/f values that are X or Z count as mismatches.
- Reset asserted mid-run aborts immediately to reset values. No partial result is retained.

Optional Feature:
- Macro: UDP_FIRST_FAIL_CAPTURE_EN.
- Defined: adds outputs first_fail_valid(1), first_fail_idx(4), first_fail_ef(2, observed {e,f}).
  - At the first mismatching sample edge of a run, captures vec_idx and {e,f} and sets first_fail_valid=1.
  - Captured values are held until the next accepted start or reset, both of which clear all three to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Correct DUT, SETTLE_CYCLES=10, start pulse -> vectors step every 10 cycles; done=1 exactly 160 cycles after start; err_count=0; pass=1; final a,b,c,d=1,1,1,0.
- DUT with F stuck-at-0 -> 5 errors (D=1, ABC in {000,010,100,110,111}); err_count=5; pass=0.
- DUT with E inverted -> every vector mismatches; err_count=16; pass=0. With UDP_FIRST_FAIL_CAPTURE_EN: first_fail_idx=0, first_fail_ef=2'b00.
- start pulsed again at cycle 50 of a run -> ignored; done still at cycle 160. A new start in DONE -> done drops, err_count clears, and the run repeats.
- reset_b driven low at cycle 73 -> in the same cycle all outputs return to 0 and busy=0. After release with no start, outputs stay idle.
- SETTLE_CYCLES=0 -> behaves as 1; done=1 exactly 16 cycles after start; correct DUT gives pass=1.
